// File: rtl/seg_scroll_scan_if.sv
// -----------------------------------------------------------------------------
// seg_scroll_scan_if
//   Bundles the digit-stream handshake, the clear strobe and the display
//   outputs of seg_scroll_scan.
//
//   Handshake (valid/ready): a digit transfers on a rising clk edge where
//   in_valid and in_ready are both 1. The source holds in_digit stable while
//   in_valid is high and not yet accepted; in_ready never depends on in_valid.
//
//   Signals
//     clear        source -> block  synchronous clear of buffer and hold
//     in_valid     source -> block  in_digit is valid
//     in_digit[3:0]source -> block  hex digit code
//     in_ready     block -> source  a digit can be accepted this cycle
//     seg[6:0]     block -> display {g,f,e,d,c,b,a}, active-low
//     an[N-1:0]    block -> display digit enables, active-low, bit 0 rightmost
//     scroll_tick  block -> source  one-cycle pulse after each scroll step
//
//   Modports: master = digit source / display side, slave = seg_scroll_scan.
// -----------------------------------------------------------------------------
interface seg_scroll_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  clear;
  logic                  in_valid;
  logic [3:0]            in_digit;
  logic                  in_ready;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  scroll_tick;

  modport master (
    output clear,
    output in_valid,
    output in_digit,
    input  in_ready,
    input  seg,
    input  an,
    input  scroll_tick
  );

  modport slave (
    input  clear,
    input  in_valid,
    input  in_digit,
    output in_ready,
    output seg,
    output an,
    output scroll_tick
  );
endinterface

// File: rtl/seg_scroll_scan.sv
// -----------------------------------------------------------------------------
// seg_scroll_scan
//   Scrolling, time-multiplexed seven-segment display stage. Digits arrive over
//   a valid/ready handshake into a one-entry holding register. Every
//   SCROLL_SCANS scan slots a scroll step shifts the digit buffer one place to
//   the left (entry 0 = rightmost digit) and loads the held digit, or a blank
//   when nothing is pending and IDLE_BLANK=1. The display is scanned one digit
//   per SCAN_DIV clocks; segment and anode outputs are registered.
//
//   Parameters
//     NUM_DIGITS   number of physical digits (2..8)
//     SCAN_DIV     clk cycles per scan slot (>=2)
//     SCROLL_SCANS scan slots per scroll step (>=1)
//     IDLE_BLANK   1: an idle step shifts in a blank, 0: buffer holds
//
//   Ports
//     clk    system clock
//     reset  asynchronous, active-low reset
//     bus    seg_scroll_scan_if.slave (clear, in_valid/in_digit/in_ready,
//            seg, an, scroll_tick); its NUM_DIGITS must match this module's
// -----------------------------------------------------------------------------
module seg_scroll_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int SCROLL_SCANS = 200,
  parameter bit IDLE_BLANK   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  seg_scroll_scan_if.slave   bus
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  // A single-scan scroll period still needs a 1-bit counter to exist.
  localparam int SCR_W = (SCROLL_SCANS > 1) ? $clog2(SCROLL_SCANS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_SCANS - 1);

  // Buffer entry: {blank, code}. The blank flag keeps "no digit" distinct
  // from code 0.
  typedef logic [4:0] entry_t;
  localparam entry_t BLANK = 5'b1_0000;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]      presc_q,      presc_d;
  logic [IDX_W-1:0]      scan_idx_q,   scan_idx_d;
  logic [SCR_W-1:0]      scroll_cnt_q, scroll_cnt_d;
  entry_t                buf_q [NUM_DIGITS];
  entry_t                buf_d [NUM_DIGITS];
  logic                  hold_valid_q, hold_valid_d;
  logic [3:0]            hold_digit_q, hold_digit_d;
  logic [6:0]            seg_q,        seg_d;
  logic [NUM_DIGITS-1:0] an_q,         an_d;
  logic                  scroll_tick_q;

  logic scan_tick;
  logic step;
  logic accept;

  // ---------------------------------------------------------------------------
  // Segment decode, active-low {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] decode(entry_t e);
    logic [6:0] s;
    if (e[4]) begin
      s = SEG_OFF;
    end else begin
      case (e[3:0])
        4'h0:    s = 7'h40;
        4'h1:    s = 7'h79;
        4'h2:    s = 7'h24;
        4'h3:    s = 7'h30;
        4'h4:    s = 7'h19;
        4'h5:    s = 7'h12;
        4'h6:    s = 7'h02;
        4'h7:    s = 7'h78;
        4'h8:    s = 7'h00;
        4'h9:    s = 7'h10;
        4'hA:    s = 7'h08;
        4'hB:    s = 7'h03;
        4'hC:    s = 7'h46;
        4'hD:    s = 7'h21;
        4'hE:    s = 7'h06;
        default: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Timebase: prescaler -> scan slot -> scroll step
  // ---------------------------------------------------------------------------
  assign scan_tick = (presc_q == PRE_LAST);
  assign step      = scan_tick && (scroll_cnt_q == SCR_LAST);

  always_comb begin
    presc_d      = presc_q + PRE_W'(1);
    scan_idx_d   = scan_idx_q;
    scroll_cnt_d = scroll_cnt_q;
    if (scan_tick) begin
      presc_d      = '0;
      scan_idx_d   = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
      scroll_cnt_d = (scroll_cnt_q == SCR_LAST) ? '0 : scroll_cnt_q + SCR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------
  assign bus.in_ready = ~hold_valid_q;
  assign accept       = bus.in_valid & ~hold_valid_q;

  // A step consuming the hold and a new capture cannot coincide: in_ready is
  // low whenever the hold is full. A capture in a step cycle with the hold
  // empty lands after the step has already taken its idle action.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_digit_d = hold_digit_q;
    if (bus.clear) begin
      hold_valid_d = 1'b0;
    end else if (step && hold_valid_q) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      hold_valid_d = 1'b1;
      hold_digit_d = bus.in_digit;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit buffer: shift toward the left on a step, oldest entry falls off
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (bus.clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_d[i] = BLANK;
      end
    end else if (step && (hold_valid_q || IDLE_BLANK)) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        buf_d[i] = buf_q[i-1];
      end
      buf_d[0] = hold_valid_q ? {1'b0, hold_digit_q} : BLANK;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: registered, so it trails scan_idx and the buffer by 1 cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << scan_idx_q);
    seg_d = decode(buf_q[scan_idx_q]);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q       <= '0;
      scan_idx_q    <= '0;
      scroll_cnt_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= BLANK;
      end
      hold_valid_q  <= 1'b0;
      hold_digit_q  <= '0;
      seg_q         <= SEG_OFF;
      an_q          <= '1;
      scroll_tick_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      scan_idx_q    <= scan_idx_d;
      scroll_cnt_q  <= scroll_cnt_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        buf_q[i] <= buf_d[i];
      end
      hold_valid_q  <= hold_valid_d;
      hold_digit_q  <= hold_digit_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      // Pulses regardless of clear or an idle hold: it marks the step time.
      scroll_tick_q <= step;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.scroll_tick = scroll_tick_q;

endmodule
